// File: rtl/guess_controller_if.sv
// Submission handshake between the guess controller and the scorer.
interface guess_controller_if;
    logic        submit_valid;
    logic        submit_ready;
    logic [11:0] submit_guess;
    logic        busy;

    modport master (
        output submit_valid,
        output submit_guess,
        output busy,
        input  submit_ready
    );

    modport slave (
        input  submit_valid,
        input  submit_guess,
        input  busy,
        output submit_ready
    );
endinterface

// File: rtl/guess_controller.sv
// Guess editor: four colour slots edited with a cursor, submitted to a scorer
// over a valid/ready handshake, with a browsable ring of past guesses.
module guess_controller #(
    parameter int unsigned NUM_COLORS = 6,
    parameter int unsigned HIST_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_up,
    input  logic                  btn_submit,
    input  logic                  btn_mode,
    guess_controller_if.master    sub,
    output logic                  blink_enable,
    output logic [1:0]            blink_led,
    output logic [2:0]            guess_rgb0,
    output logic [2:0]            guess_rgb1,
    output logic [2:0]            guess_rgb2,
    output logic [2:0]            guess_rgb3,
    output logic [2:0]            history_rgb0,
    output logic [2:0]            history_rgb1,
    output logic [2:0]            history_rgb2,
    output logic [2:0]            history_rgb3,
    output logic [4:0]            hist_count
);

    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned GUESS_W = 4 * SLOT_W;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned PTR_W   = $clog2(HIST_DEPTH);

    localparam logic [1:0] S_EDIT    = 2'd0;
    localparam logic [1:0] S_SUBMIT  = 2'd1;
    localparam logic [1:0] S_HISTORY = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [1:0]         cursor_q,     cursor_d;
    logic [SLOT_W-1:0]  slot_q [4];
    logic [SLOT_W-1:0]  slot_d [4];
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]   hist_count_q, hist_count_d;
    logic [PTR_W-1:0]   view_q,       view_d;
    logic               valid_q,      valid_d;
    logic               busy_q,       busy_d;
    logic [GUESS_W-1:0] guess_q,      guess_d;
    logic               blink_en_q,   blink_en_d;
    logic [1:0]         blink_led_q,  blink_led_d;
    logic [SLOT_W-1:0]  hist_rgb_q [4];
    logic [SLOT_W-1:0]  hist_rgb_d [4];
    logic [GUESS_W-1:0] hist_mem_q [HIST_DEPTH];

    logic               act_mode, act_submit, act_left, act_right, act_up;
    logic               accept;
    logic               mem_we;
    logic [PTR_W-1:0]   rd_addr;
    logic [GUESS_W-1:0] rd_entry;

    // Next-state and registered-output logic; only the top-priority button is acted on
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        slot_d       = slot_q;
        wr_ptr_d     = wr_ptr_q;
        hist_count_d = hist_count_q;
        view_d       = view_q;
        guess_d      = guess_q;
        mem_we       = 1'b0;

        act_mode   = btn_mode;
        act_submit = btn_submit & ~btn_mode;
        act_left   = btn_left   & ~btn_mode & ~btn_submit;
        act_right  = btn_right  & ~btn_mode & ~btn_submit & ~btn_left;
        act_up     = btn_up     & ~btn_mode & ~btn_submit & ~btn_left & ~btn_right;

        accept = (state_q == S_SUBMIT) & valid_q & sub.submit_ready;

        case (state_q)
            S_EDIT: begin
                if (act_mode) begin
                    if (hist_count_q != CNT_W'(0)) begin
                        state_d = S_HISTORY;
                        view_d  = PTR_W'(0);
                    end
                end else if (act_submit) begin
                    state_d = S_SUBMIT;
                    guess_d = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
                end else if (act_left) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (act_right) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (act_up) begin
                    slot_d[cursor_q] = (slot_q[cursor_q] >= SLOT_W'(NUM_COLORS))
                                       ? SLOT_W'(1) : slot_q[cursor_q] + SLOT_W'(1);
                end
            end
            S_SUBMIT: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (hist_count_q != CNT_W'(HIST_DEPTH)) begin
                        hist_count_d = hist_count_q + CNT_W'(1);
                    end
                    state_d = S_EDIT;
                end
            end
            S_HISTORY: begin
                if (act_mode) begin
                    state_d = S_EDIT;
                end else if (act_left) begin
                    if ((CNT_W'(view_q) + CNT_W'(1)) < hist_count_q) begin
                        view_d = view_q + PTR_W'(1);
                    end
                end else if (act_right) begin
                    if (view_q != PTR_W'(0)) begin
                        view_d = view_q - PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_EDIT;
            end
        endcase

        valid_d     = (state_d == S_SUBMIT);
        busy_d      = (state_d == S_SUBMIT);
        blink_en_d  = (state_d != S_HISTORY);
        blink_led_d = cursor_d;

        // View index counts back from the newest entry
        rd_addr  = wr_ptr_q - PTR_W'(1) - view_q;
        rd_entry = hist_mem_q[rd_addr];
        for (int i = 0; i < 4; i++) begin
            hist_rgb_d[i] = (hist_count_q == CNT_W'(0))
                            ? SLOT_W'(0) : rd_entry[i*SLOT_W +: SLOT_W];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EDIT;
            cursor_q     <= 2'd0;
            wr_ptr_q     <= PTR_W'(0);
            hist_count_q <= CNT_W'(0);
            view_q       <= PTR_W'(0);
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            guess_q      <= GUESS_W'(0);
            blink_en_q   <= 1'b1;
            blink_led_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i]     <= SLOT_W'(1);
                hist_rgb_q[i] <= SLOT_W'(0);
            end
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            wr_ptr_q     <= wr_ptr_d;
            hist_count_q <= hist_count_d;
            view_q       <= view_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            guess_q      <= guess_d;
            blink_en_q   <= blink_en_d;
            blink_led_q  <= blink_led_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i]     <= slot_d[i];
                hist_rgb_q[i] <= hist_rgb_d[i];
            end
        end
    end

    // History storage; reset blocks the write so an abandoned offer leaves no trace
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            hist_mem_q[wr_ptr_q] <= guess_q;
        end
    end

    assign sub.submit_valid = valid_q;
    assign sub.submit_guess = guess_q;
    assign sub.busy         = busy_q;
    assign blink_enable     = blink_en_q;
    assign blink_led        = blink_led_q;
    assign guess_rgb0       = slot_q[0];
    assign guess_rgb1       = slot_q[1];
    assign guess_rgb2       = slot_q[2];
    assign guess_rgb3       = slot_q[3];
    assign history_rgb0     = hist_rgb_q[0];
    assign history_rgb1     = hist_rgb_q[1];
    assign history_rgb2     = hist_rgb_q[2];
    assign history_rgb3     = hist_rgb_q[3];
    assign hist_count       = hist_count_q;

endmodule

// File: tb/tb_guess_controller.sv
// Self-checking bench for guess_controller: directed scenarios plus random
// button/ready/reset traffic, checked every cycle against a queue-based model.
module tb_guess_controller;

    localparam int NC = 6;
    localparam int HD = 8;

    // Button vector order {mode, submit, left, right, up}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_U    = 5'b00001;
    localparam logic [4:0] B_R    = 5'b00010;
    localparam logic [4:0] B_L    = 5'b00100;
    localparam logic [4:0] B_S    = 5'b01000;
    localparam logic [4:0] B_M    = 5'b10000;

    localparam int ME = 0;
    localparam int MS = 1;
    localparam int MH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
    logic       btn_submit = 1'b0, btn_mode = 1'b0;
    logic       blink_enable;
    logic [1:0] blink_led;
    logic [2:0] guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0] history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic [4:0] hist_count;

    guess_controller_if sub_if ();

    guess_controller #(.NUM_COLORS(NC), .HIST_DEPTH(HD)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_submit   (btn_submit),
        .btn_mode     (btn_mode),
        .sub          (sub_if),
        .blink_enable (blink_enable),
        .blink_led    (blink_led),
        .guess_rgb0   (guess_rgb0),
        .guess_rgb1   (guess_rgb1),
        .guess_rgb2   (guess_rgb2),
        .guess_rgb3   (guess_rgb3),
        .history_rgb0 (history_rgb0),
        .history_rgb1 (history_rgb1),
        .history_rgb2 (history_rgb2),
        .history_rgb3 (history_rgb3),
        .hist_count   (hist_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state
    int          m_state = ME;
    int          m_cursor = 0;
    int          m_slot [4] = '{1, 1, 1, 1};
    logic [11:0] m_hist [$];
    int          m_age = 0;
    logic [11:0] m_guess = 12'd0;
    logic [2:0]  m_hrgb [4] = '{3'd0, 3'd0, 3'd0, 3'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the inputs held stable since the falling edge
    always @(posedge clk) begin : model
        logic [11:0] e;
        if (rst) begin
            m_state  = ME;
            m_cursor = 0;
            for (int i = 0; i < 4; i++) begin
                m_slot[i] = 1;
                m_hrgb[i] = 3'd0;
            end
            m_hist.delete();
            m_age   = 0;
            m_guess = 12'd0;
        end else begin
            // history view is the entry selected during the previous cycle
            e = (m_hist.size() == 0) ? 12'd0 : m_hist[m_hist.size() - 1 - m_age];
            for (int i = 0; i < 4; i++) m_hrgb[i] = e[i*3 +: 3];
            case (m_state)
                ME: begin
                    if (btn_mode) begin
                        if (m_hist.size() > 0) begin
                            m_state = MH;
                            m_age   = 0;
                        end
                    end else if (btn_submit) begin
                        m_guess = {3'(m_slot[3]), 3'(m_slot[2]), 3'(m_slot[1]), 3'(m_slot[0])};
                        m_state = MS;
                    end else if (btn_left) begin
                        m_cursor = (m_cursor + 3) % 4;
                    end else if (btn_right) begin
                        m_cursor = (m_cursor + 1) % 4;
                    end else if (btn_up) begin
                        m_slot[m_cursor] = (m_slot[m_cursor] == NC) ? 1 : m_slot[m_cursor] + 1;
                    end
                end
                MS: begin
                    if (sub_if.submit_ready) begin
                        m_hist.push_back(m_guess);
                        if (m_hist.size() > HD) void'(m_hist.pop_front());
                        m_state = ME;
                    end
                end
                default: begin
                    if (btn_mode) begin
                        m_state = ME;
                    end else if (btn_submit) begin
                        m_state = MH;
                    end else if (btn_left) begin
                        if (m_age < m_hist.size() - 1) m_age++;
                    end else if (btn_right) begin
                        if (m_age > 0) m_age--;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("submit_valid", 32'(sub_if.submit_valid), 32'(m_state == MS));
            chk("busy",         32'(sub_if.busy),         32'(m_state == MS));
            chk("submit_guess", 32'(sub_if.submit_guess), 32'(m_guess));
            chk("blink_enable", 32'(blink_enable),        32'(m_state != MH));
            chk("blink_led",    32'(blink_led),           32'(m_cursor));
            chk("guess_rgb0",   32'(guess_rgb0),          32'(m_slot[0]));
            chk("guess_rgb1",   32'(guess_rgb1),          32'(m_slot[1]));
            chk("guess_rgb2",   32'(guess_rgb2),          32'(m_slot[2]));
            chk("guess_rgb3",   32'(guess_rgb3),          32'(m_slot[3]));
            chk("history_rgb0", 32'(history_rgb0),        32'(m_hrgb[0]));
            chk("history_rgb1", 32'(history_rgb1),        32'(m_hrgb[1]));
            chk("history_rgb2", 32'(history_rgb2),        32'(m_hrgb[2]));
            chk("history_rgb3", 32'(history_rgb3),        32'(m_hrgb[3]));
            chk("hist_count",   32'(hist_count),          32'(m_hist.size()));
        end
    end

    // One clock with the given inputs; returns at the falling edge with inputs cleared
    task automatic step(input logic [4:0] b, input logic rdy, input logic rs);
        {btn_mode, btn_submit, btn_left, btn_right, btn_up} = b;
        sub_if.submit_ready = rdy;
        rst = rs;
        @(posedge clk);
        @(negedge clk);
        {btn_mode, btn_submit, btn_left, btn_right, btn_up} = 5'b0;
        sub_if.submit_ready = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        sub_if.submit_ready = 1'b0;
        step(B_NONE, 1'b1, 1'b1);
        chk_en = 1'b1;

        // Reset state
        chk("rst_hist_count", 32'(hist_count), 32'd0);
        chk("rst_blink_en",   32'(blink_enable), 32'd1);
        chk("rst_slot0",      32'(guess_rgb0), 32'd1);
        chk("rst_valid",      32'(sub_if.submit_valid), 32'd0);

        // Cursor moves and colour advance
        step(B_R, 1'b0, 1'b0);
        step(B_R, 1'b0, 1'b0);
        repeat (3) step(B_U, 1'b0, 1'b0);
        chk("edit_led",   32'(blink_led), 32'd2);
        chk("edit_slot2", 32'(guess_rgb2), 32'd4);
        chk("edit_slot1", 32'(guess_rgb1), 32'd1);

        // Cursor wrap, colour wrap, priority
        repeat (3) step(B_L, 1'b0, 1'b0);
        chk("cursor_wrap", 32'(blink_led), 32'd3);
        repeat (5) step(B_U, 1'b0, 1'b0);
        chk("slot_at_max", 32'(guess_rgb3), 32'd6);
        step(B_U, 1'b0, 1'b0);
        chk("colour_wrap", 32'(guess_rgb3), 32'd1);
        step(B_L | B_U, 1'b0, 1'b0);
        chk("prio_led",  32'(blink_led), 32'd2);
        chk("prio_slot", 32'(guess_rgb3), 32'd1);

        // Mode with empty history is ignored
        step(B_M, 1'b0, 1'b0);
        chk("mode_empty", 32'(blink_enable), 32'd1);

        // Held offer while scorer is not ready
        step(B_S, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(sub_if.submit_valid), 32'd1);
            chk("hold_busy",  32'(sub_if.busy), 32'd1);
            chk("hold_guess", 32'(sub_if.submit_guess), 32'h309);
            step(B_U, 1'b0, 1'b0);
        end
        step(B_NONE, 1'b1, 1'b0);
        chk("accept_count", 32'(hist_count), 32'd1);
        chk("accept_valid", 32'(sub_if.submit_valid), 32'd0);
        chk("accept_edit",  32'(blink_enable), 32'd1);
        chk("accept_slot2", 32'(guess_rgb2), 32'd4);

        // Reset while an offer is outstanding
        step(B_S, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(sub_if.submit_valid), 32'd1);
        step(B_NONE, 1'b1, 1'b1);
        chk("rst_sub_valid", 32'(sub_if.submit_valid), 32'd0);
        chk("rst_sub_count", 32'(hist_count), 32'd0);

        // Nine distinct submissions overflow the history
        for (int k = 1; k <= 9; k++) begin
            if (k == 6) begin
                step(B_R, 1'b0, 1'b0);
                step(B_U, 1'b0, 1'b0);
                step(B_L, 1'b0, 1'b0);
            end
            step(B_U, 1'b0, 1'b0);
            step(B_S, 1'b0, 1'b0);
            step(B_NONE, 1'b1, 1'b0);
        end
        chk("full_count", 32'(hist_count), 32'd8);
        step(B_M, 1'b0, 1'b0);
        step(B_NONE, 1'b0, 1'b0);
        chk("hist_view_blink", 32'(blink_enable), 32'd0);
        chk("newest_rgb0", 32'(history_rgb0), 32'd4);
        chk("newest_rgb1", 32'(history_rgb1), 32'd2);
        chk("newest_rgb2", 32'(history_rgb2), 32'd1);
        repeat (7) step(B_L, 1'b0, 1'b0);
        step(B_NONE, 1'b0, 1'b0);
        chk("oldest_rgb0", 32'(history_rgb0), 32'd3);
        chk("oldest_rgb1", 32'(history_rgb1), 32'd1);
        step(B_L, 1'b0, 1'b0);
        step(B_NONE, 1'b0, 1'b0);
        chk("sat_rgb0", 32'(history_rgb0), 32'd3);
        chk("sat_rgb1", 32'(history_rgb1), 32'd1);
        step(B_R, 1'b0, 1'b0);
        step(B_NONE, 1'b0, 1'b0);
        chk("newer_rgb0", 32'(history_rgb0), 32'd4);
        step(B_M, 1'b0, 1'b0);
        chk("back_edit", 32'(blink_enable), 32'd1);

        // Random traffic
        repeat (4000) begin
            logic [4:0] b;
            for (int j = 0; j < 5; j++) b[j] = ($urandom_range(3) == 0);
            step(b, 1'($urandom_range(1)), 1'($urandom_range(399) == 0));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
